// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: run controller for the single-cycle processor.
// Runs NUM_PROGS programs back to back. For each one it drives the CPU reset and
// start PC, waits for the PC to reach the end address, checks the result, and
// aborts the rest of the run if the watchdog runs out.
// Optional feature macro: PROC_SEQ_CYCLECOUNT_EN adds the last_cycles output,
// which reports the RUN cycle count of the most recently finished program.
module proc_test_sequencer #(
  parameter int DATA_W       = 64,
  parameter int PC_W         = 64,
  parameter int NUM_PROGS    = 2,
  parameter int WDOG_W       = 16,
  parameter int WDOG_LIMIT   = 'hFF,
  parameter int RESET_CYCLES = 2,
  parameter int CHAIN        = 1
) (
  input  logic                           CLK,
  input  logic                           resetl,
  input  logic                           start,
  input  logic [NUM_PROGS*PC_W-1:0]      prog_startpc,
  input  logic [NUM_PROGS*PC_W-1:0]      prog_endpc,
  input  logic [NUM_PROGS*DATA_W-1:0]    prog_expect,
  output logic                           cpu_resetl,
  output logic [PC_W-1:0]                cpu_startpc,
  input  logic [PC_W-1:0]                cpu_currentpc,
  input  logic [DATA_W-1:0]              cpu_result,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_PROGS):0]     cur_prog,
  output logic [NUM_PROGS-1:0]           pass_vec,
  output logic [NUM_PROGS-1:0]           fail_vec,
  output logic [$clog2(NUM_PROGS+1)-1:0] pass_count,
  output logic                           all_passed,
  output logic                           wdog_expired
`ifdef PROC_SEQ_CYCLECOUNT_EN
  ,
  output logic [WDOG_W-1:0]              last_cycles
`endif
);

  localparam int CP_W  = $clog2(NUM_PROGS) + 1;
  localparam int CNT_W = $clog2(NUM_PROGS + 1);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);

  localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};
  localparam logic [WDOG_W-1:0] WDOG_TERM = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RESET_CYCLES - 1);
  localparam logic [CP_W-1:0]   PROG_LAST = CP_W'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_NEXT,
    ST_ABORT,
    ST_DONE
  } state_t;

  state_t state, state_d;

  logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
  logic [WDOG_W-1:0] wdog, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;

  logic                  cpu_resetl_d;
  logic [PC_W-1:0]       cpu_startpc_d;
  logic                  busy_d;
  logic                  done_d;
  logic [CP_W-1:0]       cur_prog_d;
  logic [CP_W-1:0]       cur_prog_inc;
  logic [NUM_PROGS-1:0]  pass_vec_d;
  logic [NUM_PROGS-1:0]  fail_vec_d;
  logic [CNT_W-1:0]      pass_count_d;
  logic                  all_passed_d;
  logic                  wdog_expired_d;
`ifdef PROC_SEQ_CYCLECOUNT_EN
  logic [WDOG_W-1:0]     last_cycles_d;
`endif

  logic [PC_W-1:0]   cur_start;
  logic [PC_W-1:0]   nxt_start;
  logic [PC_W-1:0]   cur_end;
  logic [DATA_W-1:0] cur_expect;
  logic              pc_reached;
  logic              result_ok;

  assign cur_prog_inc = cur_prog + CP_W'(1);
  assign wdog_inc     = (wdog == WDOG_MAX) ? wdog : wdog + WDOG_W'(1);
  assign pc_reached   = (cpu_currentpc >= cur_end);
  assign result_ok    = (cpu_result == cur_expect);

  // Pick the table entries for the active program and the one after it.
  always_comb begin
    cur_start  = '0;
    nxt_start  = '0;
    cur_end    = '0;
    cur_expect = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (cur_prog == CP_W'(i)) begin
        cur_start  = prog_startpc[i*PC_W +: PC_W];
        cur_end    = prog_endpc[i*PC_W +: PC_W];
        cur_expect = prog_expect[i*DATA_W +: DATA_W];
      end
      if (cur_prog_inc == CP_W'(i)) begin
        nxt_start = prog_startpc[i*PC_W +: PC_W];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d        = state;
    rst_cnt_d      = rst_cnt;
    wdog_d         = wdog;
    cpu_resetl_d   = cpu_resetl;
    cpu_startpc_d  = cpu_startpc;
    busy_d         = busy;
    done_d         = done;
    cur_prog_d     = cur_prog;
    pass_vec_d     = pass_vec;
    fail_vec_d     = fail_vec;
    pass_count_d   = pass_count;
    wdog_expired_d = wdog_expired;
`ifdef PROC_SEQ_CYCLECOUNT_EN
    last_cycles_d  = last_cycles;
`endif

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_RESET;
          pass_vec_d     = '0;
          fail_vec_d     = '0;
          pass_count_d   = '0;
          wdog_expired_d = 1'b0;
          done_d         = 1'b0;
          busy_d         = 1'b1;
          cur_prog_d     = '0;
          rst_cnt_d      = '0;
          cpu_resetl_d   = 1'b0;
          cpu_startpc_d  = prog_startpc[PC_W-1:0];
        end
      end

      ST_RESET: begin
        cpu_resetl_d  = 1'b0;
        cpu_startpc_d = cur_start;
        if (rst_cnt == RC_LAST) begin
          cpu_resetl_d = 1'b1;
          wdog_d       = '0;
          rst_cnt_d    = '0;
          state_d      = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt + RC_W'(1);
        end
      end

      ST_RUN: begin
        wdog_d = wdog_inc;
        if (pc_reached) begin
          for (int i = 0; i < NUM_PROGS; i++) begin
            if (cur_prog == CP_W'(i)) begin
              if (result_ok) begin
                pass_vec_d[i] = 1'b1;
              end else begin
                fail_vec_d[i] = 1'b1;
              end
            end
          end
          if (result_ok) begin
            pass_count_d = pass_count + CNT_W'(1);
          end
`ifdef PROC_SEQ_CYCLECOUNT_EN
          last_cycles_d = wdog_inc;
`endif
          state_d = ST_NEXT;
        end else if (wdog == WDOG_TERM) begin
`ifdef PROC_SEQ_CYCLECOUNT_EN
          last_cycles_d = wdog_inc;
`endif
          state_d = ST_ABORT;
        end
      end

      ST_NEXT: begin
        if (cur_prog == PROG_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cur_prog_d = cur_prog_inc;
          if (CHAIN != 0) begin
            wdog_d  = '0;
            state_d = ST_RUN;
          end else begin
            rst_cnt_d     = '0;
            cpu_resetl_d  = 1'b0;
            cpu_startpc_d = nxt_start;
            state_d       = ST_RESET;
          end
        end
      end

      ST_ABORT: begin
        for (int i = 0; i < NUM_PROGS; i++) begin
          if (CP_W'(i) >= cur_prog) begin
            fail_vec_d[i] = 1'b1;
          end
        end
        wdog_expired_d = 1'b1;
        cpu_resetl_d   = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b1;
        state_d        = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    all_passed_d = done_d && (pass_count_d == CNT_W'(NUM_PROGS));
  end

  // State and output registers, cleared asynchronously while resetl is low.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      wdog         <= '0;
      cpu_resetl   <= 1'b0;
      cpu_startpc  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_prog     <= '0;
      pass_vec     <= '0;
      fail_vec     <= '0;
      pass_count   <= '0;
      all_passed   <= 1'b0;
      wdog_expired <= 1'b0;
`ifdef PROC_SEQ_CYCLECOUNT_EN
      last_cycles  <= '0;
`endif
    end else begin
      state        <= state_d;
      rst_cnt      <= rst_cnt_d;
      wdog         <= wdog_d;
      cpu_resetl   <= cpu_resetl_d;
      cpu_startpc  <= cpu_startpc_d;
      busy         <= busy_d;
      done         <= done_d;
      cur_prog     <= cur_prog_d;
      pass_vec     <= pass_vec_d;
      fail_vec     <= fail_vec_d;
      pass_count   <= pass_count_d;
      all_passed   <= all_passed_d;
      wdog_expired <= wdog_expired_d;
`ifdef PROC_SEQ_CYCLECOUNT_EN
      last_cycles  <= last_cycles_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Testbench for proc_test_sequencer: one chained instance and one
// reset-per-program instance, each driving a small PC+=4 CPU model.
module tb_proc_test_sequencer;

  localparam int DW = 64;
  localparam int PW = 64;
  localparam int NP = 2;
  localparam logic [63:0] GOOD1 = 64'h1234_5678_9abc_def0;
  localparam logic [63:0] BAD1  = 64'h1234_5678_9abc_def1;

  logic CLK = 1'b0;
  logic resetl;

  always #5 CLK = ~CLK;

  // chained instance
  logic             start_c;
  logic [NP*PW-1:0] startpc_c;
  logic [NP*PW-1:0] endpc_c;
  logic [NP*DW-1:0] expect_c;
  logic             cpu_resetl_c;
  logic [PW-1:0]    cpu_startpc_c;
  logic [PW-1:0]    pc_c = '0;
  logic [DW-1:0]    result_c;
  logic             busy_c, done_c, all_passed_c, wdog_expired_c;
  logic [1:0]       cur_prog_c, pass_vec_c, fail_vec_c, pass_count_c;
  logic             stuck_c;
  logic [63:0]      res1_c;
`ifdef PROC_SEQ_CYCLECOUNT_EN
  logic [15:0]      last_cycles_c;
  logic [15:0]      last_cycles_r;
`endif

  // reset-per-program instance
  logic             start_r;
  logic [NP*PW-1:0] startpc_r;
  logic [NP*PW-1:0] endpc_r;
  logic [NP*DW-1:0] expect_r;
  logic             cpu_resetl_r;
  logic [PW-1:0]    cpu_startpc_r;
  logic [PW-1:0]    pc_r = '0;
  logic [DW-1:0]    result_r;
  logic             busy_r, done_r, all_passed_r, wdog_expired_r;
  logic [1:0]       cur_prog_r, pass_vec_r, fail_vec_r, pass_count_r;

  proc_test_sequencer #(.CHAIN(1)) dut_c (
`ifdef PROC_SEQ_CYCLECOUNT_EN
    .last_cycles   (last_cycles_c),
`endif
    .CLK           (CLK),
    .resetl        (resetl),
    .start         (start_c),
    .prog_startpc  (startpc_c),
    .prog_endpc    (endpc_c),
    .prog_expect   (expect_c),
    .cpu_resetl    (cpu_resetl_c),
    .cpu_startpc   (cpu_startpc_c),
    .cpu_currentpc (pc_c),
    .cpu_result    (result_c),
    .busy          (busy_c),
    .done          (done_c),
    .cur_prog      (cur_prog_c),
    .pass_vec      (pass_vec_c),
    .fail_vec      (fail_vec_c),
    .pass_count    (pass_count_c),
    .all_passed    (all_passed_c),
    .wdog_expired  (wdog_expired_c)
  );

  proc_test_sequencer #(.CHAIN(0)) dut_r (
`ifdef PROC_SEQ_CYCLECOUNT_EN
    .last_cycles   (last_cycles_r),
`endif
    .CLK           (CLK),
    .resetl        (resetl),
    .start         (start_r),
    .prog_startpc  (startpc_r),
    .prog_endpc    (endpc_r),
    .prog_expect   (expect_r),
    .cpu_resetl    (cpu_resetl_r),
    .cpu_startpc   (cpu_startpc_r),
    .cpu_currentpc (pc_r),
    .cpu_result    (result_r),
    .busy          (busy_r),
    .done          (done_r),
    .cur_prog      (cur_prog_r),
    .pass_vec      (pass_vec_r),
    .fail_vec      (fail_vec_r),
    .pass_count    (pass_count_r),
    .all_passed    (all_passed_r),
    .wdog_expired  (wdog_expired_r)
  );

  // CPU models: PC loads startpc while held in reset, else advances by 4 (or sticks at 0x10)
  always @(posedge CLK) begin
    if (!cpu_resetl_c)  pc_c <= cpu_startpc_c;
    else if (stuck_c)   pc_c <= 64'h10;
    else                pc_c <= pc_c + 64'd4;
  end

  always @(posedge CLK) begin
    if (!cpu_resetl_r)  pc_r <= cpu_startpc_r;
    else                pc_r <= pc_r + 64'd4;
  end

  assign result_c = (pc_c == endpc_c[PW-1:0])    ? 64'hF :
                    (pc_c == endpc_c[2*PW-1:PW]) ? res1_c : 64'h0;
  assign result_r = (pc_r == 64'h30) ? 64'hF :
                    (pc_r == 64'h58) ? GOOD1 : 64'h0;

  // Count cycles with the CPU released while a run is in progress
  int run_cycles_c = 0;
  always @(negedge CLK) begin
    if (start_c)                         run_cycles_c = 0;
    else if (busy_c && cpu_resetl_c)     run_cycles_c++;
  end

  // Record each CPU reset stretch of the reset-per-program instance
  int          low_len = 0;
  int          lens[$];
  logic [63:0] spcs[$];
  logic [63:0] last_spc = '0;
  always @(negedge CLK) begin
    if (start_r) begin
      low_len = 0;
      lens.delete();
      spcs.delete();
    end else if (busy_r && !cpu_resetl_r) begin
      low_len++;
      last_spc = cpu_startpc_r;
    end else if (low_len > 0) begin
      lens.push_back(low_len);
      spcs.push_back(last_spc);
      low_len = 0;
    end
  end

  typedef struct {
    string       name;
    logic [63:0] end0;
    logic [63:0] end1;
    logic [63:0] res1;
    logic        stuck;
    logic [63:0] pass_v;
    logic [63:0] fail_v;
    logic [63:0] pcount;
    logic [63:0] cprog;
    logic [63:0] all_p;
    logic [63:0] wexp;
    logic [63:0] cres;
    logic [63:0] cycles;
    logic [63:0] last0;
  } vec_t;

  vec_t vecs[5];
  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passes++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK); #1;
    endpc_c = {v.end1, v.end0};
    res1_c  = v.res1;
    stuck_c = v.stuck;
    start_c = 1'b1;
    @(posedge CLK); #1;
    start_c = 1'b0;
  endtask

  task automatic waitDoneC(input string tag);
    int n = 0;
    while (!done_c && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, " done"}, 64'(done_c), 64'd1);
  endtask

  initial begin
    vecs[0] = '{"chain_pass",  64'h30,  64'h58,  GOOD1, 1'b0, 64'd3, 64'd0, 64'd2, 64'd1, 64'd1, 64'd0, 64'd1, 64'd24,  64'd13};
    vecs[1] = '{"chain_fail1", 64'h30,  64'h58,  BAD1,  1'b0, 64'd1, 64'd2, 64'd1, 64'd1, 64'd0, 64'd0, 64'd1, 64'd24,  64'd13};
    vecs[2] = '{"stuck_abort", 64'h30,  64'h58,  GOOD1, 1'b1, 64'd0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0, 64'd256, 64'd255};
    vecs[3] = '{"pc_wdog_tie", 64'h3F8, 64'h400, GOOD1, 1'b0, 64'd3, 64'd0, 64'd2, 64'd1, 64'd1, 64'd0, 64'd1, 64'd258, 64'd255};
    vecs[4] = '{"wdog_first",  64'h3FC, 64'h400, GOOD1, 1'b0, 64'd0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0, 64'd256, 64'd255};

    resetl    = 1'b0;
    start_c   = 1'b0;
    start_r   = 1'b0;
    stuck_c   = 1'b0;
    res1_c    = GOOD1;
    startpc_c = {64'h100, 64'h0};
    endpc_c   = {64'h58, 64'h30};
    expect_c  = {GOOD1, 64'hF};
    startpc_r = {64'h40, 64'h0};
    endpc_r   = {64'h58, 64'h30};
    expect_r  = {GOOD1, 64'hF};

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst busy",        64'(busy_c),         64'd0);
    checkOutput("rst done",        64'(done_c),         64'd0);
    checkOutput("rst cpu_resetl",  64'(cpu_resetl_c),   64'd0);
    checkOutput("rst cpu_startpc", cpu_startpc_c,       64'd0);
    checkOutput("rst cur_prog",    64'(cur_prog_c),     64'd0);
    checkOutput("rst pass_vec",    64'(pass_vec_c),     64'd0);
    checkOutput("rst fail_vec",    64'(fail_vec_c),     64'd0);
    checkOutput("rst pass_count",  64'(pass_count_c),   64'd0);
    checkOutput("rst all_passed",  64'(all_passed_c),   64'd0);
    checkOutput("rst wdog_exp",    64'(wdog_expired_c), 64'd0);
    @(posedge CLK); #1;
    resetl = 1'b1;

    // table-driven runs on the chained instance
    for (int t = 0; t < 5; t++) begin
      int n = 0;
      $display("[TB] vector %s", vecs[t].name);
      applyStimulus(vecs[t]);
      while (!(pass_vec_c[0] || fail_vec_c[0]) && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      checkOutput({vecs[t].name, " prog0 verdict"}, 64'(pass_vec_c[0] | fail_vec_c[0]), 64'd1);
`ifdef PROC_SEQ_CYCLECOUNT_EN
      checkOutput({vecs[t].name, " last_cycles0"}, 64'(last_cycles_c), vecs[t].last0);
`endif
      waitDoneC(vecs[t].name);
      @(negedge CLK);
      checkOutput({vecs[t].name, " pass_vec"},    64'(pass_vec_c),     vecs[t].pass_v);
      checkOutput({vecs[t].name, " fail_vec"},    64'(fail_vec_c),     vecs[t].fail_v);
      checkOutput({vecs[t].name, " pass_count"},  64'(pass_count_c),   vecs[t].pcount);
      checkOutput({vecs[t].name, " cur_prog"},    64'(cur_prog_c),     vecs[t].cprog);
      checkOutput({vecs[t].name, " all_passed"},  64'(all_passed_c),   vecs[t].all_p);
      checkOutput({vecs[t].name, " wdog_exp"},    64'(wdog_expired_c), vecs[t].wexp);
      checkOutput({vecs[t].name, " cpu_resetl"},  64'(cpu_resetl_c),   vecs[t].cres);
      checkOutput({vecs[t].name, " busy"},        64'(busy_c),         64'd0);
      checkOutput({vecs[t].name, " cpu_startpc"}, cpu_startpc_c,       64'd0);
      checkOutput({vecs[t].name, " run_cycles"},  64'(run_cycles_c),   vecs[t].cycles);
    end

    // reset-per-program instance: CPU reset stretches and start PCs
    begin
      int n = 0;
      @(posedge CLK); #1;
      start_r = 1'b1;
      @(posedge CLK); #1;
      start_r = 1'b0;
      while (!done_r && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      checkOutput("nochain done", 64'(done_r), 64'd1);
      @(negedge CLK);
      checkOutput("nochain pass_vec",  64'(pass_vec_r),   64'd3);
      checkOutput("nochain all_pass",  64'(all_passed_r), 64'd1);
      checkOutput("nochain stretches", 64'(lens.size()),  64'd2);
      checkOutput("nochain len0", (lens.size() > 0) ? 64'(lens[0]) : 64'hFFFF, 64'd2);
      checkOutput("nochain len1", (lens.size() > 1) ? 64'(lens[1]) : 64'hFFFF, 64'd2);
      checkOutput("nochain spc0", (spcs.size() > 0) ? spcs[0] : 64'hFFFF, 64'h0);
      checkOutput("nochain spc1", (spcs.size() > 1) ? spcs[1] : 64'hFFFF, 64'h40);
    end

    // start ignored while busy, then asynchronous reset mid-run
    begin
      int n = 0;
      applyStimulus(vecs[0]);
      while (!pass_vec_c[0] && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      checkOutput("midrun prog0 pass", 64'(pass_vec_c[0]), 64'd1);
      repeat (2) @(negedge CLK);
      @(posedge CLK); #1;
      start_c = 1'b1;
      @(posedge CLK); #1;
      start_c = 1'b0;
      @(negedge CLK);
      checkOutput("ign busy",       64'(busy_c),       64'd1);
      checkOutput("ign cur_prog",   64'(cur_prog_c),   64'd1);
      checkOutput("ign cpu_resetl", 64'(cpu_resetl_c), 64'd1);
      checkOutput("ign pass_vec",   64'(pass_vec_c),   64'd1);
      resetl = 1'b0;
      #1;
      checkOutput("async busy",       64'(busy_c),       64'd0);
      checkOutput("async cpu_resetl", 64'(cpu_resetl_c), 64'd0);
      checkOutput("async cur_prog",   64'(cur_prog_c),   64'd0);
      checkOutput("async pass_vec",   64'(pass_vec_c),   64'd0);
      checkOutput("async pass_count", 64'(pass_count_c), 64'd0);
      checkOutput("async done",       64'(done_c),       64'd0);
      @(posedge CLK); #1;
      resetl = 1'b1;
      repeat (2) @(posedge CLK);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
